decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode/register-read stage of the 16-bit MIPS pipeline. Produces the operands and controls consumed by the execute stage:
  - read data 1 and 2
  - sign-extended immediate
  - ALUSrc and ALUOp
- Contains an 8x16 register file with a writeback port.
- Contains the ID/EX pipeline register, with stall, flush and load-use hazard bubble insertion.

Parameters:
- DATA_W, 16, datapath width.
- REG_ADDR_W, 3, register index width; register count is 2**REG_ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_Instruction  in  16  instruction from IF/ID.
- in_Valid  in  1  in_Instruction is a real instruction.
- in_Stall  in  1  downstream hold; ID/EX keeps its contents.
- in_Flush  in  1  branch squash; ID/EX loads a bubble.
- in_WB_RegWrite  in  1  writeback enable.
- in_WB_WriteReg  in  3  writeback register index.
- in_WB_WriteData  in  16  writeback data.
- O_Read_Data_1  out  16  rs operand to execute.
- O_Read_Data_2  out  16  rt operand to execute.
- O_Immediate  out  16  sign-extended imm6.
- O_ALUSrc  out  1  1 = ALU operand B is the immediate.
- O_ALUOp  out  2  00 add, 01 sub, 10 R-type (use funct), 11 and.
- O_Funct  out  3  funct field.
- O_WriteReg  out  3  destination: rd for R-type, rt otherwise.
- O_RegWrite, O_MemRead, O_MemWrite, O_Branch  out  1 each  controls.
- O_Valid  out  1  ID/EX holds a real instruction.
- O_Hold_Upstream  out  1  IF/ID and PC must hold this cycle.

Behaviour:
- Instruction fields:
  - op [15:12], rs [11:9], rt [8:6], rd [5:3], funct [2:0], imm6 [5:0].
  - Sign extension: O_Immediate = {10{imm6[5]}, imm6}.
- Opcode decode:
  - 0000 R-type: RegWrite, ALUOp 10.
  - 0100 addi: RegWrite, ALUSrc, ALUOp 00.
  - 0101 andi: RegWrite, ALUSrc, ALUOp 11.
  - 1011 lw: RegWrite, MemRead, ALUSrc, ALUOp 00.
  - 1111 sw: MemWrite, ALUSrc, ALUOp 00.
  - 1000 beq: Branch, ALUOp 01.
  - Any other opcode: all controls 0, O_Valid still follows in_Valid (decoded as NOP).
- Register file:
  - 8 entries; r0 reads 0 always, and writes to r0 are ignored.
  - Write occurs at the clock edge when in_WB_RegWrite=1.
  - Reads are combinational.
  - Write-through bypass: a read of the index being written in the same cycle returns in_WB_WriteData (except r0).
- Load-use hazard (combinational): hazard = O_Valid & O_MemRead & in_Valid & (O_WriteReg != 0) & any of:
  - O_WriteReg == rs, for all opcodes except none;
  - O_WriteReg == rt, for R-type, sw, beq.
- O_Hold_Upstream = hazard | in_Stall.
- ID/EX update priority each edge, highest first:
  1. rst: all outputs 0, register file cleared to 0.
  2. in_Flush: bubble (O_Valid=0, all controls 0, data fields 0).
  3. in_Stall: hold all outputs.
  4. hazard: bubble.
  5. Otherwise load decoded values; if in_Valid=0, load a bubble.
- Latency:
  - Instruction to ID/EX outputs: 1 cycle.
  - A writeback is visible to a decode in the same cycle (via bypass).
- Reset mid-operation clears the pipeline register and the register file in the same edge; O_Hold_Upstream is 0 after reset.
- Flush together with stall: flush wins and O_Valid=0 next cycle.
- A stalled instruction keeps its operand values captured at load. Later writebacks are not reflected; forwarding is the execute stage's responsibility.

Decomposition:
- Shared package (mips_pkg):
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ;
  - ALUOp constants: ALU_ADD, ALU_SUB, ALU_RTYPE, ALU_AND;
  - DATA_W and the register-index width.
- One sub-module: register_file (8x16, two read ports, one write port, bypass, r0 hardwired). Decode, hazard logic and ID/EX stay in decode_stage.

Test Plan:
1. Reset, then writeback r3=0x1234; decode R-type rs=3 rt=0 next cycle -> O_Read_Data_1=0x1234, O_Read_Data_2=0, O_ALUOp=10, O_WriteReg=rd, O_Valid=1.
2. addi with imm6=6'b111110 -> O_Immediate=0xFFFE, O_ALUSrc=1, O_ALUOp=00; andi with imm6=0x1F -> O_Immediate=0x001F, O_ALUOp=11.
3. Same-cycle write r5=0xBEEF while decoding rs=5 -> O_Read_Data_1=0xBEEF next cycle; write to r0 with 0xFFFF -> r0 still reads 0.
4. lw r2 followed by add using rs=2 -> O_Hold_Upstream=1 for exactly one cycle, one bubble (O_Valid=0), then add loads. lw r2 followed by addi with rt=2 (rs≠2) -> no hazard.
5. in_Stall=1 for 3 cycles -> outputs unchanged, O_Hold_Upstream=1. in_Flush and in_Stall both 1 -> O_Valid=0 and controls 0 next cycle.
6. rst asserted while a valid lw sits in ID/EX -> all outputs 0 next cycle and all registers read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the 16-bit MIPS pipeline.
// Opcodes, ALU operation codes and the ID/EX bundle.
package mips_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_ANDI  = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    typedef struct packed {
        logic [DATA_W-1:0]     read_data_1;
        logic [DATA_W-1:0]     read_data_2;
        logic [DATA_W-1:0]     immediate;
        logic                  alu_src;
        logic [1:0]            alu_op;
        logic [2:0]            funct;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  valid;
    } id_ex_t;

endpackage

// File: rtl/register_file.sv
// 8x16 register file: two combinational read ports, one write port,
// write-through bypass, r0 hardwired to zero.
module register_file
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    localparam int NREG = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok;

    assign wr_ok = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Same-cycle writeback is forwarded so decode never sees stale data.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wr_ok && (waddr == raddr1)) rdata1 = wdata;
        if (wr_ok && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage with load-use bubble insertion
// and the ID/EX pipeline register.
module decode_stage
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           in_Instruction,
    input  logic                  in_Valid,
    input  logic                  in_Stall,
    input  logic                  in_Flush,
    input  logic                  in_WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] in_WB_WriteReg,
    input  logic [DATA_W-1:0]     in_WB_WriteData,
    output logic [DATA_W-1:0]     O_Read_Data_1,
    output logic [DATA_W-1:0]     O_Read_Data_2,
    output logic [DATA_W-1:0]     O_Immediate,
    output logic                  O_ALUSrc,
    output logic [1:0]            O_ALUOp,
    output logic [2:0]            O_Funct,
    output logic [REG_ADDR_W-1:0] O_WriteReg,
    output logic                  O_RegWrite,
    output logic                  O_MemRead,
    output logic                  O_MemWrite,
    output logic                  O_Branch,
    output logic                  O_Valid,
    output logic                  O_Hold_Upstream
);

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [5:0]            imm6;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic                  uses_rt;
    logic                  hazard;
    id_ex_t                dec;
    id_ex_t                q;

    assign op   = in_Instruction[15:12];
    assign rs   = in_Instruction[11:9];
    assign rt   = in_Instruction[8:6];
    assign rd   = in_Instruction[5:3];
    assign imm6 = in_Instruction[5:0];

    register_file u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (in_WB_RegWrite),
        .waddr  (in_WB_WriteReg),
        .wdata  (in_WB_WriteData),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    always_comb begin
        dec             = '0;
        dec.read_data_1 = rdata1;
        dec.read_data_2 = rdata2;
        dec.immediate   = {{(DATA_W-6){imm6[5]}}, imm6};
        dec.funct       = in_Instruction[2:0];
        dec.write_reg   = (op == OP_RTYPE) ? rd : rt;
        dec.valid       = 1'b1;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_RTYPE;
            end
            (op == OP_ADDI): begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            (op == OP_ANDI): begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_AND;
            end
            (op == OP_LW): begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            (op == OP_SW): begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            (op == OP_BEQ): begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    // rt is a source only for R-type, sw and beq; rs always counts.
    assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);

    assign hazard = q.valid && q.mem_read && in_Valid
                 && (q.write_reg != '0)
                 && ((q.write_reg == rs)
                  || (uses_rt && (q.write_reg == rt)));

    assign O_Hold_Upstream = hazard || in_Stall;

    always_ff @(posedge clk) begin
        if (rst || in_Flush) begin
            q <= '0;
        end else if (in_Stall) begin
            q <= q;
        end else if (hazard || !in_Valid) begin
            q <= '0;
        end else begin
            q <= dec;
        end
    end

    assign O_Read_Data_1 = q.read_data_1;
    assign O_Read_Data_2 = q.read_data_2;
    assign O_Immediate   = q.immediate;
    assign O_ALUSrc      = q.alu_src;
    assign O_ALUOp       = q.alu_op;
    assign O_Funct       = q.funct;
    assign O_WriteReg    = q.write_reg;
    assign O_RegWrite    = q.reg_write;
    assign O_MemRead     = q.mem_read;
    assign O_MemWrite    = q.mem_write;
    assign O_Branch      = q.branch;
    assign O_Valid       = q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed plan steps followed by
// random traffic, all compared against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_Instruction;
    logic        in_Valid;
    logic        in_Stall;
    logic        in_Flush;
    logic        in_WB_RegWrite;
    logic [2:0]  in_WB_WriteReg;
    logic [15:0] in_WB_WriteData;
    logic [15:0] O_Read_Data_1;
    logic [15:0] O_Read_Data_2;
    logic [15:0] O_Immediate;
    logic        O_ALUSrc;
    logic [1:0]  O_ALUOp;
    logic [2:0]  O_Funct;
    logic [2:0]  O_WriteReg;
    logic        O_RegWrite;
    logic        O_MemRead;
    logic        O_MemWrite;
    logic        O_Branch;
    logic        O_Valid;
    logic        O_Hold_Upstream;

    decode_stage dut (
        .clk             (clk),
        .rst             (rst),
        .in_Instruction  (in_Instruction),
        .in_Valid        (in_Valid),
        .in_Stall        (in_Stall),
        .in_Flush        (in_Flush),
        .in_WB_RegWrite  (in_WB_RegWrite),
        .in_WB_WriteReg  (in_WB_WriteReg),
        .in_WB_WriteData (in_WB_WriteData),
        .O_Read_Data_1   (O_Read_Data_1),
        .O_Read_Data_2   (O_Read_Data_2),
        .O_Immediate     (O_Immediate),
        .O_ALUSrc        (O_ALUSrc),
        .O_ALUOp         (O_ALUOp),
        .O_Funct         (O_Funct),
        .O_WriteReg      (O_WriteReg),
        .O_RegWrite      (O_RegWrite),
        .O_MemRead       (O_MemRead),
        .O_MemWrite      (O_MemWrite),
        .O_Branch        (O_Branch),
        .O_Valid         (O_Valid),
        .O_Hold_Upstream (O_Hold_Upstream)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [2:0]  funct;
        logic [2:0]  wreg;
        logic        regw;
        logic        memr;
        logic        memw;
        logic        br;
        logic        valid;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] regs [8];
    exp_t        m;
    logic        hold_seen;

    function automatic exp_t bubble();
        exp_t e;
        e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.alusrc = 0;
        e.aluop = 0; e.funct = 0; e.wreg = 0; e.regw = 0;
        e.memr = 0; e.memw = 0; e.br = 0; e.valid = 0;
        return e;
    endfunction

    // Architectural view: reads see the register array after this
    // cycle's writeback has been applied.
    function automatic exp_t decode(input logic [15:0] ins);
        exp_t e = bubble();
        int op = int'(ins[15:12]);
        e.valid = 1;
        e.rd1 = (ins[11:9] == 0) ? 16'h0 : regs[ins[11:9]];
        e.rd2 = (ins[8:6] == 0) ? 16'h0 : regs[ins[8:6]];
        e.imm = 16'(signed'(ins[5:0]));
        e.funct = ins[2:0];
        e.wreg = (op == 0) ? ins[5:3] : ins[8:6];
        case (op)
            0:  begin e.regw = 1; e.aluop = 2; end
            4:  begin e.regw = 1; e.alusrc = 1; e.aluop = 0; end
            5:  begin e.regw = 1; e.alusrc = 1; e.aluop = 3; end
            11: begin e.regw = 1; e.memr = 1; e.alusrc = 1; end
            15: begin e.memw = 1; e.alusrc = 1; end
            8:  begin e.br = 1; e.aluop = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic load_use(input logic [15:0] ins, input logic v);
        int op = int'(ins[15:12]);
        logic rt_src = (op == 0) || (op == 15) || (op == 8);
        if (!(m.valid && m.memr && v && m.wreg != 0)) return 0;
        return (m.wreg == ins[11:9]) || (rt_src && m.wreg == ins[8:6]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_rd1"}, O_Read_Data_1, m.rd1);
        check({tag, "_rd2"}, O_Read_Data_2, m.rd2);
        check({tag, "_imm"}, O_Immediate, m.imm);
        check({tag, "_alusrc"}, 16'(O_ALUSrc), 16'(m.alusrc));
        check({tag, "_aluop"}, 16'(O_ALUOp), 16'(m.aluop));
        check({tag, "_funct"}, 16'(O_Funct), 16'(m.funct));
        check({tag, "_wreg"}, 16'(O_WriteReg), 16'(m.wreg));
        check({tag, "_regw"}, 16'(O_RegWrite), 16'(m.regw));
        check({tag, "_memr"}, 16'(O_MemRead), 16'(m.memr));
        check({tag, "_memw"}, 16'(O_MemWrite), 16'(m.memw));
        check({tag, "_br"}, 16'(O_Branch), 16'(m.br));
        check({tag, "_valid"}, 16'(O_Valid), 16'(m.valid));
    endtask

    task automatic step(input string tag, input logic [15:0] ins,
                        input logic v, input logic st, input logic fl,
                        input logic we, input logic [2:0] wr,
                        input logic [15:0] wd, input logic r);
        logic haz;
        in_Instruction = ins; in_Valid = v; in_Stall = st;
        in_Flush = fl; in_WB_RegWrite = we; in_WB_WriteReg = wr;
        in_WB_WriteData = wd; rst = r;
        #1;
        haz = load_use(ins, v);
        hold_seen = O_Hold_Upstream;
        check({tag, "_hold"}, 16'(O_Hold_Upstream), 16'(haz | st));
        @(posedge clk);
        if (r) begin
            m = bubble();
            for (int i = 0; i < 8; i++) regs[i] = 0;
        end else begin
            if (we && wr != 0) regs[wr] = wd;
            if (fl) m = bubble();
            else if (st) m = m;
            else if (haz || !v) m = bubble();
            else m = decode(ins);
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [15:0] rnd_instr();
        logic [3:0] ops [8];
        ops[0] = 4'h0; ops[1] = 4'h4; ops[2] = 4'h5; ops[3] = 4'hB;
        ops[4] = 4'hF; ops[5] = 4'h8; ops[6] = 4'h3; ops[7] = 4'hB;
        return {ops[$urandom_range(7)], 12'($urandom)};
    endfunction

    initial begin
        m = bubble();
        for (int i = 0; i < 8; i++) regs[i] = 0;
        hold_seen = 0;

        step("rst0", 16'h0, 0, 0, 0, 0, 0, 0, 1);
        step("rst1", 16'h0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_valid", 16'(O_Valid), 16'h0);

        step("wb_r3", 16'h0, 0, 0, 0, 1, 3, 16'h1234, 0);
        step("t1_r", {4'h0, 3'd3, 3'd0, 3'd4, 3'd2}, 1, 0, 0, 0, 0, 0, 0);
        check("t1_rd1_c", O_Read_Data_1, 16'h1234);
        check("t1_rd2_c", O_Read_Data_2, 16'h0);
        check("t1_aluop_c", 16'(O_ALUOp), 16'h2);
        check("t1_wreg_c", 16'(O_WriteReg), 16'h4);

        step("t2_addi", {4'h4, 3'd3, 3'd1, 6'b111110}, 1, 0, 0, 0, 0, 0, 0);
        check("t2_imm_c", O_Immediate, 16'hFFFE);
        step("t2_andi", {4'h5, 3'd3, 3'd1, 6'h1F}, 1, 0, 0, 0, 0, 0, 0);
        check("t2_imm2_c", O_Immediate, 16'h001F);
        check("t2_aluop_c", 16'(O_ALUOp), 16'h3);

        step("t3_byp", {4'h4, 3'd5, 3'd1, 6'h01}, 1, 0, 0, 1, 5, 16'hBEEF, 0);
        check("t3_rd1_c", O_Read_Data_1, 16'hBEEF);
        step("t3_r0", {4'h0, 3'd0, 3'd0, 3'd1, 3'd0}, 1, 0, 0, 1, 0, 16'hFFFF, 0);
        check("t3_r0_c", O_Read_Data_1, 16'h0);

        step("t4_lw", {4'hB, 3'd1, 3'd2, 6'h0}, 1, 0, 0, 0, 0, 0, 0);
        step("t4_add", {4'h0, 3'd2, 3'd1, 3'd3, 3'd0}, 1, 0, 0, 0, 0, 0, 0);
        check("t4_hold1_c", 16'(hold_seen), 16'h1);
        check("t4_bubble_c", 16'(O_Valid), 16'h0);
        step("t4_add2", {4'h0, 3'd2, 3'd1, 3'd3, 3'd0}, 1, 0, 0, 0, 0, 0, 0);
        check("t4_hold0_c", 16'(hold_seen), 16'h0);
        check("t4_load_c", 16'(O_Valid), 16'h1);
        step("t4_lw2", {4'hB, 3'd1, 3'd2, 6'h0}, 1, 0, 0, 0, 0, 0, 0);
        step("t4_addi", {4'h4, 3'd1, 3'd2, 6'h3}, 1, 0, 0, 0, 0, 0, 0);
        check("t4_nohaz_c", 16'(hold_seen), 16'h0);

        for (int i = 0; i < 3; i++)
            step("t5_stall", 16'h0A55, 1, 1, 0, 1, 6, 16'h7777, 0);
        check("t5_keep_c", 16'(O_ALUSrc), 16'h1);
        step("t5_flst", 16'h0A55, 1, 1, 1, 0, 0, 0, 0);
        check("t5_flush_c", 16'(O_Valid), 16'h0);

        step("t6_lw", {4'hB, 3'd6, 3'd2, 6'h4}, 1, 0, 0, 0, 0, 0, 0);
        step("t6_rst", {4'h0, 3'd3, 3'd5, 3'd1, 3'd0}, 1, 0, 0, 0, 0, 0, 1);
        step("t6_rd", {4'h0, 3'd3, 3'd5, 3'd1, 3'd0}, 1, 0, 0, 0, 0, 0, 0);
        check("t6_rd1_c", O_Read_Data_1, 16'h0);
        check("t6_rd2_c", O_Read_Data_2, 16'h0);

        for (int i = 0; i < 400; i++) begin
            step("rnd", rnd_instr(),
                 $urandom_range(7) != 0,
                 $urandom_range(5) == 0,
                 $urandom_range(9) == 0,
                 $urandom_range(1) == 1,
                 3'($urandom),
                 16'($urandom),
                 $urandom_range(63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
